// File: rtl/alu_pkg.sv
// Shared ALU op encodings, LFSR/MISR tap constant and BIST state enum.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_SLT = 4'd9
  } alu_op_e;

  localparam int NUM_ALU_OPS = 10;

  // x^32 + x^22 + x^2 + x + 1 : feedback taps on bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // One shift of the 32-bit Fibonacci register; shared by LFSRs and the MISR
  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return {q[30:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/alu_bist_lfsr32.sv
// 32-bit operand LFSR with seed reload and step enable.
module lfsr32
  import alu_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  output logic [31:0] q
);

  // Reset and load both restore the seed; otherwise step when enabled
  always_ff @(posedge clk) begin
    if (rst || load) q <= SEED;
    else if (en)     q <= lfsr_step(q);
  end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self test: LFSR operand generation, op sweep, MISR compaction.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          N_VECTORS  = 16,
  parameter logic [31:0] SEED       = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        start,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALU_control,
  input  logic [31:0] ALU_result,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [31:0] SEED_A   = (SEED  == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] SEED_B   = (~SEED == 32'h0) ? 32'h1 : ~SEED;
  localparam logic [15:0] VEC_LAST = 16'(N_VECTORS - 1);
  localparam logic [3:0]  OP_LAST  = 4'(NUM_ALU_OPS - 1);

  bist_state_e state, state_nxt;
  logic [15:0] vec_cnt;
  logic [3:0]  op_idx;
  logic [31:0] lfsr_a, lfsr_b;
  logic        run, go_run, last;

  assign run    = (state == ST_RUN);
  assign go_run = start && !run;
  assign last   = run && (vec_cnt == VEC_LAST) && (op_idx == OP_LAST);

  lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk(CLOCK), .rst(RESET), .load(go_run), .en(run), .q(lfsr_a)
  );

  lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk(CLOCK), .rst(RESET), .load(go_run), .en(run), .q(lfsr_b)
  );

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: start restarts from IDLE or DONE, ignored while running
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
      ST_RUN:           if (last)  state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Vector/op counters and MISR; cleared on run entry, frozen outside RUN
  always_ff @(posedge CLOCK) begin
    if (RESET || go_run) begin
      signature <= '0;
      vec_cnt   <= '0;
      op_idx    <= '0;
    end else if (run) begin
      signature <= lfsr_step(signature) ^ ALU_result ^ {31'b0, zero};
      if (vec_cnt == VEC_LAST) begin
        vec_cnt <= '0;
        op_idx  <= last ? 4'd0 : op_idx + 4'd1;
      end else begin
        vec_cnt <= vec_cnt + 16'd1;
      end
    end
  end

  // ALU drive and status are only live in their owning state
  always_comb begin
    A           = run ? lfsr_a : 32'h0;
    B           = run ? lfsr_b : 32'h0;
    ALU_control = run ? op_idx : 4'h0;
    busy        = run;
    done        = (state == ST_DONE);
    pass        = done && (signature == GOLDEN_SIG);
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: reference ALU, table-driven run, scoreboard.
module tb_alu_bist;
  import alu_pkg::*;

  function automatic logic [31:0] lstep(input logic [31:0] q);
    logic fb;
    fb = q[31] ^ q[21] ^ q[1] ^ q[0];
    return {q[30:0], fb};
  endfunction

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
      default: return 32'h0;
    endcase
  endfunction

  // Reference signature; zm = constant result 0 / zero 1, flip_idx = vector with bit0 inverted
  function automatic logic [31:0] gold(input int n, input logic [31:0] seed, input bit zm,
                                       input int flip_idx);
    logic [31:0] sa, sb, s, r;
    logic z;
    int k;
    sa = (seed == 32'h0) ? 32'h1 : seed;
    sb = (~seed == 32'h0) ? 32'h1 : ~seed;
    s = 32'h0;
    k = 0;
    for (int op = 0; op < 10; op++) begin
      for (int v = 0; v < n; v++) begin
        r = zm ? 32'h0 : alu_f(4'(op), sa, sb);
        z = zm ? 1'b1 : (r == 32'h0);
        if (k == flip_idx) r[0] = ~r[0];
        s = lstep(s) ^ r ^ {31'b0, z};
        sa = lstep(sa);
        sb = lstep(sb);
        k++;
      end
    end
    return s;
  endfunction

  localparam logic [31:0] SEED16 = 32'hACE1_2468;
  localparam logic [31:0] GOLD1  = gold(1, 32'h1, 1'b0, -1);
  localparam logic [31:0] GOLD16 = gold(16, SEED16, 1'b0, -1);

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sig;
  } vec_t;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    int          len;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start1 = 1'b0, start16 = 1'b0, zmode1 = 1'b0, flip1 = 1'b0;
  logic [31:0] a1, b1, res1, sig1, a16, b16, res16, sig16;
  logic [3:0]  ctl1, ctl16;
  logic        z1, busy1, done1, pass1, z16, busy16, done16, pass16;
  logic [31:0] t1;

  int checks = 0, errors = 0;
  exp_t sb_q[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  // Reference ALU for the N_VECTORS=1 instance, with zero-mode and bit0 fault injection
  always_comb begin
    t1   = alu_f(ctl1, a1, b1);
    z1   = zmode1 ? 1'b1 : (t1 == 32'h0);
    res1 = (zmode1 ? 32'h0 : t1) ^ {31'b0, flip1};
  end

  // Reference ALU for the default-size instance
  always_comb begin
    res16 = alu_f(ctl16, a16, b16);
    z16   = (res16 == 32'h0);
  end

  alu_bist #(.N_VECTORS(1), .SEED(32'h1), .GOLDEN_SIG(GOLD1)) u_dut1 (
    .CLOCK(clk), .RESET(rst), .start(start1), .A(a1), .B(b1), .ALU_control(ctl1),
    .ALU_result(res1), .zero(z1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  alu_bist #(.N_VECTORS(16), .SEED(SEED16), .GOLDEN_SIG(GOLD16)) u_dut16 (
    .CLOCK(clk), .RESET(rst), .start(start16), .A(a16), .B(b16), .ALU_control(ctl16),
    .ALU_result(res16), .zero(z16), .busy(busy16), .done(done16), .pass(pass16), .signature(sig16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_outputs1(input string nm);
    chk({nm, "_A"}, a1, 32'h0);
    chk({nm, "_B"}, b1, 32'h0);
    chk({nm, "_ctl"}, {28'b0, ctl1}, 32'h0);
    chk1({nm, "_busy"}, busy1, 1'b0);
    chk1({nm, "_done"}, done1, 1'b0);
    chk1({nm, "_pass"}, pass1, 1'b0);
    chk({nm, "_sig"}, sig1, 32'h0);
  endtask

  // Full run on the small instance; options: start pulse mid-run, bit0 fault at run cycle flip_at
  task automatic run1(input string nm, input bit mid, input int flip_at, input logic [31:0] esig);
    exp_t e;
    int len;
    e.sig = esig; e.pass = (esig == GOLD1); e.len = 10;
    sb_q.push_back(e);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    len = 0;
    while (busy1 && len < 200) begin
      len++;
      start1 = mid && (len == 3);
      flip1  = (len == flip_at);
      @(negedge clk);
    end
    start1 = 1'b0;
    flip1  = 1'b0;
    e = sb_q.pop_front();
    chk({nm, "_len"}, 32'(len), 32'(e.len));
    chk1({nm, "_done"}, done1, 1'b1);
    chk1({nm, "_busy"}, busy1, 1'b0);
    chk({nm, "_A"}, a1, 32'h0);
    chk({nm, "_sig"}, sig1, e.sig);
    chk1({nm, "_pass"}, pass1, e.pass);
  endtask

  initial begin
    logic [31:0] sa, sb, s;
    exp_t e;
    int len;

    // Expected per-cycle operands and pre-edge signature for N_VECTORS=1, SEED=1
    sa = 32'h1; sb = 32'hFFFF_FFFE; s = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{op: 4'(i), a: sa, b: sb, sig: s};
      s  = lstep(s) ^ alu_f(4'(i), sa, sb) ^ {31'b0, (alu_f(4'(i), sa, sb) == 32'h0)};
      sa = lstep(sa);
      sb = lstep(sb);
    end

    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_outputs1("reset");
    chk1("reset16_busy", busy16, 1'b0);
    chk("reset16_sig", sig16, 32'h0);
    rst = 1'b0;

    // Table-driven first run, checked every RUN cycle
    e.sig = GOLD1; e.pass = 1'b1; e.len = 10;
    sb_q.push_back(e);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1($sformatf("tbl%0d_busy", i), busy1, 1'b1);
      chk($sformatf("tbl%0d_A", i), a1, tbl[i].a);
      chk($sformatf("tbl%0d_B", i), b1, tbl[i].b);
      chk($sformatf("tbl%0d_ctl", i), {28'b0, ctl1}, {28'b0, tbl[i].op});
      chk($sformatf("tbl%0d_sig", i), sig1, tbl[i].sig);
      if (i == 0) begin
        chk("first_A", a1, 32'h0000_0001);
        chk("first_B", b1, 32'hFFFF_FFFE);
        chk("first_res", res1, 32'hFFFF_FFFF);
      end
      if (i == 1) chk("first_sig_after_edge", sig1, 32'hFFFF_FFFF);
      @(negedge clk);
    end
    e = sb_q.pop_front();
    chk1("tbl_done_cycle11", done1, 1'b1);
    chk1("tbl_busy", busy1, 1'b0);
    chk("tbl_final_sig", sig1, e.sig);
    chk1("tbl_pass", pass1, e.pass);
    @(negedge clk);
    chk("tbl_sig_frozen", sig1, GOLD1);
    chk1("tbl_done_held", done1, 1'b1);

    // Restart from DONE, start ignored mid-run, single-bit fault, recovery
    run1("rerun", 1'b0, 0, GOLD1);
    run1("midstart", 1'b1, 0, GOLD1);
    run1("fault", 1'b0, 5, gold(1, 32'h1, 1'b0, 4));
    run1("recover", 1'b0, 0, GOLD1);

    // Reset in RUN cycle 5
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk1("pre_reset_busy", busy1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_outputs1("midreset");
    run1("after_reset", 1'b0, 0, GOLD1);

    // Reset wins over simultaneous start
    @(negedge clk) begin rst = 1'b1; start1 = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start1 = 1'b0; end
    idle_outputs1("rst_vs_start");
    @(negedge clk);
    chk1("rst_vs_start_idle", busy1, 1'b0);

    // Constant ALU: result 0, zero 1 every vector
    zmode1 = 1'b1;
    run1("zero_alu", 1'b0, 0, gold(1, 32'h1, 1'b1, -1));
    zmode1 = 1'b0;

    // Default-size instance: 160-cycle run with counter wrap
    @(negedge clk) start16 = 1'b1;
    @(negedge clk) start16 = 1'b0;
    len = 0;
    while (busy16 && len < 1000) begin
      if (len == 16) chk("n16_op1", {28'b0, ctl16}, 32'h1);
      len++;
      @(negedge clk);
    end
    chk("n16_len", 32'(len), 32'd160);
    chk1("n16_done", done16, 1'b1);
    chk("n16_sig", sig16, GOLD16);
    chk1("n16_pass", pass16, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
